// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encodings, 12-bit colour type and
// the fixed colour constants used by the pattern generator.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_t;

  typedef enum logic {
    MOVE_POS = 1'b0,
    MOVE_NEG = 1'b1
  } axis_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t WHITE  = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb12_t RED    = '{r: 4'hF, g: 4'h0, b: 4'h0};
  localparam rgb12_t DKBLUE = '{r: 4'h0, g: 4'h0, b: 4'h4};
  localparam rgb12_t BLACK  = '{r: 4'h0, g: 4'h0, b: 4'h0};

  // Each bit of the 3-bit bar code drives one full colour channel.
  function automatic rgb12_t bar_colour(input logic [2:0] c);
    return '{r: {4{c[2]}}, g: {4{c[1]}}, b: {4{c[0]}}};
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position plus a two-state direction FSM,
// advanced by SPEED on every frame tick and clamped at 0 and LIMIT.
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter int W     = 10,
  parameter int LIMIT = 768,
  parameter int SPEED = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_tick,
  output logic [W-1:0] o_pos
);

  // Compare one bit wider than the coordinate so pos+SPEED cannot wrap.
  localparam logic [W:0] LIM_E = (W+1)'(LIMIT);
  localparam logic [W:0] SPD_E = (W+1)'(SPEED);

  axis_state_t r_state;
  logic [W-1:0] r_pos;
  logic [W:0]   w_pos_ext;
  logic [W:0]   w_fwd;

  assign w_pos_ext = {1'b0, r_pos};
  assign w_fwd     = w_pos_ext + SPD_E;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MOVE_POS;
      r_pos   <= '0;
    end else if (i_tick) begin
      case (r_state)
        MOVE_POS: begin
          if (w_fwd >= LIM_E) begin
            r_pos   <= LIM_E[W-1:0];
            r_state <= MOVE_NEG;
          end else begin
            r_pos <= w_fwd[W-1:0];
          end
        end
        MOVE_NEG: begin
          if (w_pos_ext <= SPD_E) begin
            r_pos   <= '0;
            r_state <= MOVE_POS;
          end else begin
            r_pos <= r_pos - SPD_E[W-1:0];
          end
        end
        default: r_state <= MOVE_POS;
      endcase
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage behind the VGA timing generator: four test patterns,
// frame-synchronous mode switching, and syncs re-aligned to the colour.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int HZNT_WIDTH     = 800,
  parameter int VERT_HEIGHT    = 600,
  parameter int HZNT_COOR_BITS = $clog2(HZNT_WIDTH),
  parameter int VERT_COOR_BITS = $clog2(VERT_HEIGHT),
  parameter int BOX_SIZE       = 32,
  parameter int BOX_SPEED      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [HZNT_COOR_BITS-1:0] x,
  input  logic [VERT_COOR_BITS-1:0] y,
  input  logic                      in_frame,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      mode_next,
  output logic [3:0]                r,
  output logic [3:0]                g,
  output logic [3:0]                b,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic [1:0]                mode
);

  localparam int XB    = HZNT_COOR_BITS;
  localparam int YB    = VERT_COOR_BITS;
  localparam int BAR_W = HZNT_WIDTH / 8;
  localparam logic [XB:0] BOX_X = (XB+1)'(BOX_SIZE);
  localparam logic [YB:0] BOX_Y = (YB+1)'(BOX_SIZE);

  logic        r_vsync_q;
  logic        r_rst_q;
  logic        r_pending;
  logic [7:0]  r_frame_cnt;
  mode_t       r_mode;
  logic        w_tick;
  logic [XB-1:0] w_bx;
  logic [YB-1:0] w_by;

  // r_rst_q masks the first cycle after reset so a vsync already high
  // across deassert is not mistaken for a rising edge.
  assign w_tick = vsync & ~r_vsync_q & ~r_rst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_q   <= 1'b0;
      r_rst_q     <= 1'b1;
      r_pending   <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_mode      <= MODE_BARS;
    end else begin
      r_vsync_q <= vsync;
      r_rst_q   <= 1'b0;
      if (w_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        if (r_pending) r_mode <= mode_t'(r_mode + 2'd1);
        r_pending <= mode_next;
      end else begin
        r_pending <= r_pending | mode_next;
      end
    end
  end

  vga_bounce_axis #(.W(XB), .LIMIT(HZNT_WIDTH - BOX_SIZE), .SPEED(BOX_SPEED)) u_axis_x (
    .clk    (clk),
    .reset  (reset),
    .i_tick (w_tick),
    .o_pos  (w_bx)
  );

  vga_bounce_axis #(.W(YB), .LIMIT(VERT_HEIGHT - BOX_SIZE), .SPEED(BOX_SPEED)) u_axis_y (
    .clk    (clk),
    .reset  (reset),
    .i_tick (w_tick),
    .o_pos  (w_by)
  );

  logic [2:0]    w_bar_idx;
  logic [XB-1:0] w_scroll;
  logic          w_inside;
  rgb12_t        w_bars;
  rgb12_t        w_check;
  rgb12_t        w_box;
  rgb12_t        w_grad;
  rgb12_t        w_pix;

  // Bar index by comparison against constant multiples of the bar width.
  always_comb begin
    w_bar_idx = 3'd7;
    for (int k = 6; k >= 0; k--) begin
      if ({1'b0, x} < (XB+1)'((k + 1) * BAR_W)) w_bar_idx = 3'(k);
    end
  end

  assign w_bars   = bar_colour(3'd7 - w_bar_idx);
  assign w_scroll = x + XB'(r_frame_cnt);
  assign w_check  = (w_scroll[5] ^ y[5]) ? WHITE : BLACK;

  assign w_inside = ({1'b0, x} >= {1'b0, w_bx}) && ({1'b0, x} < ({1'b0, w_bx} + BOX_X)) &&
                    ({1'b0, y} >= {1'b0, w_by}) && ({1'b0, y} < ({1'b0, w_by} + BOX_Y));
  assign w_box    = w_inside ? RED : DKBLUE;
  assign w_grad   = '{r: x[XB-1 -: 4], g: y[YB-1 -: 4], b: r_frame_cnt[7:4]};

  always_comb begin
    w_pix = BLACK;
    case (r_mode)
      MODE_BARS:  w_pix = w_bars;
      MODE_CHECK: w_pix = w_check;
      MODE_BOX:   w_pix = w_box;
      MODE_GRAD:  w_pix = w_grad;
      default:    w_pix = BLACK;
    endcase
  end

  rgb12_t r_rgb_p1;
  logic   r_hsync_p1;
  logic   r_vsync_p1;

  // ---- stage p1: registered colour and syncs, one clock after inputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb_p1   <= BLACK;
      r_hsync_p1 <= 1'b0;
      r_vsync_p1 <= 1'b0;
    end else begin
      r_rgb_p1   <= in_frame ? w_pix : BLACK;
      r_hsync_p1 <= hsync;
      r_vsync_p1 <= vsync;
    end
  end

  assign r       = r_rgb_p1.r;
  assign g       = r_rgb_p1.g;
  assign b       = r_rgb_p1.b;
  assign hsync_o = r_hsync_p1;
  assign vsync_o = r_vsync_p1;
  assign mode    = r_mode;

endmodule
